// File: rtl/pb_step_gen_pkg.sv
// Shared definitions for the board step generator: debounce FSM encoding and
// default timing constants, also reused by the display scanner refresh divider.
package pb_step_gen_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    DOWN      = 2'd2,
    REL_CHK   = 2'd3
  } deb_state_e;

  localparam int DEB_CYCLES_DEF = 100000;
  localparam int RUN_DIV_DEF    = 50000000;

endpackage

// File: rtl/pb_step_gen_sync2.sv
// Two-flop synchronizer for an asynchronous board input; clears to 0 on reset.
module sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pb_step_gen.sv
// Turns the bouncing push-button and run switch into the CPU step clock, a
// one-cycle step strobe and a wrapping count of delivered steps.
module pb_step_gen
  import pb_step_gen_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int RUN_DIV    = RUN_DIV_DEF,
  parameter int CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             PB,
  input  logic             run,
  output logic             step_level,
  output logic             step_pulse,
  output logic             pb_state,
  output logic [CNT_W-1:0] step_cnt
);

  localparam int DEB_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam int DIV_W = $clog2(RUN_DIV);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(RUN_DIV / 2);

  logic pb_s;
  logic run_s;

  deb_state_e       state_q, state_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             run_prev_q;
  logic             step_level_q, step_level_d;
  logic             step_pulse_q, step_pulse_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;

  sync2 u_sync_pb (
    .clk_i  (CLK),
    .rst_ni (Reset),
    .d_i    (PB),
    .q_o    (pb_s)
  );

  sync2 u_sync_run (
    .clk_i  (CLK),
    .rst_ni (Reset),
    .d_i    (run),
    .q_o    (run_s)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      deb_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  // Each check state needs DEB_CYCLES consecutive stable samples to commit.
  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pb_s) begin
          state_d   = PRESS_CHK;
          deb_cnt_d = '0;
        end
      end
      PRESS_CHK: begin
        if (!pb_s)                     state_d   = IDLE;
        else if (deb_cnt_q == DEB_LAST) state_d   = DOWN;
        else                           deb_cnt_d = deb_cnt_q + 1'b1;
      end
      DOWN: begin
        if (!pb_s) begin
          state_d   = REL_CHK;
          deb_cnt_d = '0;
        end
      end
      REL_CHK: begin
        if (pb_s)                      state_d   = DOWN;
        else if (deb_cnt_q == DEB_LAST) state_d   = IDLE;
        else                           deb_cnt_d = deb_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pb_state = (state_q == DOWN) || (state_q == REL_CHK);
  end

  // Level is derived from the next divider value so that the registered level
  // and div_cnt stay aligned: high exactly while div_cnt < RUN_DIV/2.
  always_comb begin
    div_cnt_d    = '0;
    step_level_d = pb_state;
    if (run_s && run_prev_q) begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    end
    if (run_s) begin
      step_level_d = (div_cnt_d < DIV_HALF);
    end
    step_pulse_d = step_level_d & ~step_level_q;
    step_cnt_d   = step_cnt_q + CNT_W'(step_pulse_d);
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      div_cnt_q    <= '0;
      run_prev_q   <= 1'b0;
      step_level_q <= 1'b0;
      step_pulse_q <= 1'b0;
      step_cnt_q   <= '0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      run_prev_q   <= run_s;
      step_level_q <= step_level_d;
      step_pulse_q <= step_pulse_d;
      step_cnt_q   <= step_cnt_d;
    end
  end

  assign step_level = step_level_q;
  assign step_pulse = step_pulse_q;
  assign step_cnt   = step_cnt_q;

endmodule

// File: tb/tb_pb_step_gen.sv
// Scenario bench for pb_step_gen with DEB_CYCLES=4, RUN_DIV=8, CNT_W=8; expected
// step_cnt values are queued per step and checked as each step_pulse appears.
module tb_pb_step_gen;

  logic       CLK;
  logic       Reset;
  logic       PB;
  logic       run;
  logic       step_level;
  logic       step_pulse;
  logic       pb_state;
  logic [7:0] step_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;
  int exp_q[$];
  logic prev_pulse = 1'b0;

  pb_step_gen #(
    .DEB_CYCLES (4),
    .RUN_DIV    (8),
    .CNT_W      (8)
  ) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .PB         (PB),
    .run        (run),
    .step_level (step_level),
    .step_pulse (step_pulse),
    .pb_state   (pb_state),
    .step_cnt   (step_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pulse monitor: every pulse must be expected, isolated, and carry the queued count.
  always @(posedge CLK) begin
    #1;
    if (step_pulse === 1'b1) begin
      n_checks++;
      if (prev_pulse === 1'b1) begin
        n_fail++;
        $display("FAIL pulse_isolated: pulse high in two consecutive cycles at %0t", $time);
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: step_cnt=%0d with no pulse expected at %0t", step_cnt, $time);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (step_cnt !== 8'(e)) begin
          n_fail++;
          $display("FAIL pulse_count: step_cnt=%0d required %0d at %0t", step_cnt, e, $time);
        end
      end
    end
    prev_pulse = step_pulse;
  end

  task automatic expect_pulse();
    exp_cnt++;
    exp_q.push_back(exp_cnt % 256);
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_pulse: %0d pulses outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_drained(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge CLK); #1;
      if (exp_q.size() == 0) break;
    end
    check_drained(name);
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    PB    = 1'b0;
    run   = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if ({step_level, step_pulse, pb_state} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: level/pulse/pb=%b required 000", {step_level, step_pulse, pb_state});
    end
    n_checks++;
    if (step_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: step_cnt=%0d required 0", step_cnt);
    end
    @(negedge CLK) Reset = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    n_checks++;
    if ({step_level, step_pulse, pb_state} !== 3'b000) begin
      n_fail++;
      $display("FAIL release_no_pulse: level/pulse/pb=%b required 000", {step_level, step_pulse, pb_state});
    end
  endtask

  task automatic test_clean_press();
    expect_pulse();
    @(negedge CLK) PB = 1'b1;
    repeat (6) @(posedge CLK);
    #1;
    n_checks++;
    if (pb_state !== 1'b0) begin
      n_fail++;
      $display("FAIL press_early: pb_state=%b at edge 6 required 0", pb_state);
    end
    @(posedge CLK); #1;
    n_checks++;
    if (pb_state !== 1'b1) begin
      n_fail++;
      $display("FAIL press_latency: pb_state=%b at edge 7 required 1", pb_state);
    end
    n_checks++;
    if (step_level !== 1'b0) begin
      n_fail++;
      $display("FAIL press_level_early: step_level=%b at edge 7 required 0", step_level);
    end
    @(posedge CLK); #1;
    n_checks++;
    if ({step_level, step_pulse} !== 2'b11) begin
      n_fail++;
      $display("FAIL press_step: level/pulse=%b at edge 8 required 11", {step_level, step_pulse});
    end
    @(posedge CLK); #1;
    n_checks++;
    if ({step_level, step_pulse} !== 2'b10) begin
      n_fail++;
      $display("FAIL press_single: level/pulse=%b at edge 9 required 10", {step_level, step_pulse});
    end
    repeat (11) @(posedge CLK);
    @(negedge CLK) PB = 1'b0;
    repeat (12) @(posedge CLK);
    #1;
    n_checks++;
    if ({pb_state, step_level, step_cnt} !== {2'b00, 8'd1}) begin
      n_fail++;
      $display("FAIL press_release: pb/level=%b cnt=%0d required 00 cnt=1", {pb_state, step_level}, step_cnt);
    end
    check_drained("press");
  endtask

  task automatic test_bounce();
    logic [3:0] pat;
    pat = 4'b1010;
    for (int i = 3; i >= 0; i--) begin
      @(negedge CLK) PB = pat[i];
      @(negedge CLK);
    end
    @(negedge CLK) PB = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      n_checks++;
      if (pb_state !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce_pb: pb_state=%b cycle %0d required 0", pb_state, i);
      end
    end
    n_checks++;
    if (step_cnt !== 8'(exp_cnt)) begin
      n_fail++;
      $display("FAIL bounce_cnt: step_cnt=%0d required %0d", step_cnt, exp_cnt);
    end
  endtask

  task automatic test_release_bounce();
    expect_pulse();
    @(negedge CLK) PB = 1'b1;
    repeat (12) @(posedge CLK);
    @(negedge CLK) PB = 1'b0;
    @(negedge CLK);
    @(negedge CLK) PB = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      n_checks++;
      if ({pb_state, step_level} !== 2'b11) begin
        n_fail++;
        $display("FAIL relbounce_hold: pb/level=%b cycle %0d required 11", {pb_state, step_level}, i);
      end
    end
    @(negedge CLK) PB = 1'b0;
    repeat (12) @(posedge CLK);
    #1;
    n_checks++;
    if (pb_state !== 1'b0) begin
      n_fail++;
      $display("FAIL relbounce_release: pb_state=%b required 0", pb_state);
    end
    check_drained("relbounce");
  endtask

  task automatic test_free_run();
    for (int k = 0; k < 5; k++) expect_pulse();
    @(negedge CLK) run = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      logic lvl;
      @(posedge CLK); #1;
      lvl = (e >= 3) && (((e - 3) % 8) < 4);
      n_checks++;
      if (step_level !== lvl) begin
        n_fail++;
        $display("FAIL freerun_level: step_level=%b at edge %0d required %b", step_level, e, lvl);
      end
    end
    @(negedge CLK) run = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    n_checks++;
    if (step_level !== 1'b0 || step_cnt !== 8'(exp_cnt)) begin
      n_fail++;
      $display("FAIL freerun_exit: level=%b cnt=%0d required 0 cnt=%0d", step_level, step_cnt, exp_cnt);
    end
    check_drained("freerun");
  endtask

  task automatic test_wrap();
    while (exp_cnt < 256) expect_pulse();
    @(negedge CLK) run = 1'b1;
    wait_drained("wrap", 2300);
    @(negedge CLK) run = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    n_checks++;
    if (step_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_cnt: step_cnt=%0d after 256 pulses required 0", step_cnt);
    end
    check_drained("wrap_tail");
  endtask

  task automatic test_async_reset();
    expect_pulse();
    @(negedge CLK) run = 1'b1;
    wait_drained("async_pre", 20);
    @(posedge CLK);
    #3 Reset = 1'b0;
    #1;
    n_checks++;
    if ({step_level, step_pulse, pb_state, step_cnt} !== {3'b000, 8'd0}) begin
      n_fail++;
      $display("FAIL async_reset: level/pulse/pb=%b cnt=%0d required 000 cnt=0",
               {step_level, step_pulse, pb_state}, step_cnt);
    end
    exp_cnt = 0;
    expect_pulse();
    @(negedge CLK) Reset = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      @(posedge CLK); #1;
      n_checks++;
      if ({step_level, step_pulse} !== 2'b00) begin
        n_fail++;
        $display("FAIL async_release: level/pulse=%b at edge %0d required 00", {step_level, step_pulse}, e);
      end
    end
    wait_drained("async_post", 20);
    @(negedge CLK) run = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    check_drained("async_tail");
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_free_run();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pb_step_gen.md
Name: pb_step_gen

Overview:
- Board-input side of the single-cycle CPU board harness: turns the raw push-button and run switch into the CPU step clock (the CPU's CLK source) plus a one-cycle step strobe.
- The display scanner consumes this block's step count.
- Sits between the board oscillator domain and the CPU.
- Debounces the button with a 4-state FSM, supports free-run mode from a programmable divider, and counts delivered steps.

Parameters:
DEB_CYCLES, 100000, consecutive stable sampled cycles required to accept a button edge (min 2)
RUN_DIV, 50000000, free-run step period in CLK cycles (even, min 4)
CNT_W, 8, width of step_cnt

Ports:
CLK  in  1  board oscillator clock; all state on posedge
Reset  in  1  asynchronous, active-low reset (0 = reset)
PB  in  1  raw push-button, active-high, asynchronous, bouncing
run  in  1  raw mode switch, 1 = free-run, 0 = single-step; asynchronous
step_level  out  1  registered step clock for the CPU
step_pulse  out  1  registered one-CLK strobe, high exactly in the first cycle step_level is 1
pb_state  out  1  debounced button level
step_cnt  out  CNT_W  number of step_pulse events, wraps

Behaviour:
- Reset (Reset=0, asynchronous): synchronizer flops 0, FSM=IDLE, deb_cnt=0, div_cnt=0, step_level=0, step_pulse=0, pb_state=0, step_cnt=0.
- Reset release: first edge with Reset=1 starts normal operation. No pulse is generated at release.
- Input synchronizers:
  - PB and run each pass through 2 flops, giving pb_s and run_s.
  - All logic uses only pb_s and run_s.
- Debounce FSM on pb_s:
  - IDLE: pb_s=1 -> PRESS_CHK, deb_cnt cleared.
  - PRESS_CHK: pb_s=0 -> IDLE. deb_cnt==DEB_CYCLES-1 -> DOWN. Otherwise deb_cnt+1.
  - DOWN: pb_s=0 -> REL_CHK, deb_cnt cleared.
  - REL_CHK: pb_s=1 -> DOWN. deb_cnt==DEB_CYCLES-1 -> IDLE. Otherwise deb_cnt+1.
  - pb_state=1 in DOWN and REL_CHK; 0 in IDLE and PRESS_CHK. Registered with the state.
  - A bounce shorter than DEB_CYCLES never changes pb_state.
- Latency: clean PB rise to pb_state=1 is exactly DEB_CYCLES+3 CLK edges (2 sync + DEB_CYCLES count + 1 state register). Same for release.
- Step mode (run_s=0):
  - step_level follows pb_state with 1 cycle of register delay.
  - div_cnt held at 0.
- Run mode (run_s=1):
  - div_cnt counts 0..RUN_DIV-1 and wraps to 0.
  - step_level = 1 while div_cnt < RUN_DIV/2, registered.
  - The button FSM keeps running, but pb_state does not affect step_level.
- Mode switch:
  - Any change of run_s clears div_cnt in that cycle.
  - Step to run: step_level rises next cycle if it was low, giving one pulse.
  - Run to step: step_level takes pb_state. A fall never pulses. A rise (button held) pulses once.
- step_pulse:
  - Asserted for exactly 1 cycle on each 0->1 of step_level.
  - Never high for 2 consecutive cycles.
- step_cnt: increments by 1 in the cycle step_pulse is high; wraps from 2^CNT_W-1 to 0.
- Reset mid-press or mid-period: all state returns to reset values immediately. The button must be seen released-then-pressed (passing through IDLE) before the next pulse.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, PRESS_CHK=2'd1, DOWN=2'd2, REL_CHK=2'd3) and the default DEB_CYCLES/RUN_DIV constants, for reuse by the display scanner's refresh divider.
- One sub-module, sync2 (2-flop synchronizer, async active-low reset to 0), instantiated for PB and run.
- The FSM, divider and counter stay in pb_step_gen.

Test Plan (DEB_CYCLES=4, RUN_DIV=8, CNT_W=8):
- Clean press: PB 0->1, held 20 cycles -> pb_state=1 at edge 7 after first PB=1 sample; step_pulse single cycle one edge later; step_cnt=1.
- Bounce: PB toggles 1,0,1,0 every 2 cycles, then stays 0 -> pb_state stays 0, no step_pulse, step_cnt=0.
- Release bounce: held press, then PB 0 for 2 cycles, back to 1 -> FSM returns to DOWN, pb_state stays 1, no extra pulse.
- Free-run: run=1 for 40 cycles -> step_level high 4 / low 4 (period 8); exactly one step_pulse per period; step_cnt advances by 5 (including the entry pulse).
- Wrap: preload via 256 steps -> step_cnt reads 0 after the 256th pulse.
- Async reset: assert Reset=0 mid run-mode high phase -> all outputs 0 with no CLK edge required; after release, no pulse until next period.
